// File: rtl/hilo_mult_sequencer_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply sequencer.
// The master drives requests; the sequencer (slave) owns busy/done and the HI/LO values.
interface hilo_mult_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_mult_sequencer.sv
// HI/LO register owner: MULT/MULTU/MADD/MSUB via a radix-2 shift-add engine
// (WIDTH iterations), plus single-cycle MTHI/MTLO writes.
module hilo_mult_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    hilo_mult_sequencer_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpMadd  = 3'b010;
    localparam logic [2:0] OpMsub  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {StIdle, StMul, StFin} state_e;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] snap_q, snap_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod;

    // Magnitudes as unsigned W-bit values, so -2^(W-1) maps cleanly to 2^(W-1).
    assign abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign prod  = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        op_d     = op_q;
        snap_d   = snap_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OpMthi: begin
                            hi_d   = bus.a;
                            done_d = 1'b1;
                        end
                        OpMtlo: begin
                            lo_d   = bus.a;
                            done_d = 1'b1;
                        end
                        OpMult, OpMultu, OpMadd, OpMsub: begin
                            if (bus.op == OpMultu) begin
                                mcand_d  = bus.a;
                                mplier_d = bus.b;
                                neg_d    = 1'b0;
                            end else begin
                                mcand_d  = abs_a;
                                mplier_d = abs_b;
                                neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            end
                            op_d    = bus.op;
                            snap_d  = {hi_q, lo_q};
                            acc_d   = '0;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = StMul;
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (bus.flush) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
                    end
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    case (op_q)
                        OpMadd:  {hi_d, lo_d} = snap_q + prod;
                        OpMsub:  {hi_d, lo_d} = snap_q - prod;
                        default: {hi_d, lo_d} = prod;
                    endcase
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            op_q     <= 3'b000;
            snap_q   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            snap_q   <= snap_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
